// File: rtl/my_f_pkg.sv
// Shared types and constants for the my_f programmable 4-input function cell.
package my_f_pkg;

    typedef logic [1:0] leg_code_t;

    localparam leg_code_t LEG_ZERO = 2'b00;
    localparam leg_code_t LEG_ONE  = 2'b01;
    localparam leg_code_t LEG_D    = 2'b10;
    localparam leg_code_t LEG_ND   = 2'b11;

    localparam int unsigned NumLegs  = 8;
    localparam int unsigned CfgWidth = 2 * NumLegs;

    // Default configuration: F = A ^ B ^ C ^ D.
    localparam logic [CfgWidth-1:0] CFG_PARITY = 16'hEBBE;

    function automatic logic leg_eval(input leg_code_t code, input logic d);
        logic val;
        val = 1'b0;
        unique case (code)
            LEG_ZERO: val = 1'b0;
            LEG_ONE:  val = 1'b1;
            LEG_D:    val = d;
            LEG_ND:   val = ~d;
            default:  val = 1'b0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/my_f_if.sv
// Function-cell bus: select/data inputs, config write port and result.
// F_comb exists only when MYF_COMB_OUT_EN is defined.
interface my_f_if;
    import my_f_pkg::*;

    logic                A;
    logic                B;
    logic                C;
    logic                D;
    logic                cfg_we;
    logic [CfgWidth-1:0] cfg_data;
    logic                F;
`ifdef MYF_COMB_OUT_EN
    logic                F_comb;
`endif

`ifdef MYF_COMB_OUT_EN
    modport master (
        output A, B, C, D, cfg_we, cfg_data,
        input  F, F_comb
    );

    modport slave (
        input  A, B, C, D, cfg_we, cfg_data,
        output F, F_comb
    );
`else
    modport master (
        output A, B, C, D, cfg_we, cfg_data,
        input  F
    );

    modport slave (
        input  A, B, C, D, cfg_we, cfg_data,
        output F
    );
`endif

endinterface

// File: rtl/my_f_leg.sv
// One data leg of the function mux: decodes a 2-bit leg code against D.
module my_f_leg
    import my_f_pkg::*;
(
    input  leg_code_t code_i,
    input  logic      d_i,
    output logic      leg_o
);

    always_comb begin
        leg_o = leg_eval(code_i, d_i);
    end

endmodule

// File: rtl/my_f.sv
// Programmable 4-input Boolean cell: 8:1 mux selected by {A,B,C}, legs driven by
// 0/1/D/~D, registered output. Define MYF_COMB_OUT_EN to expose unregistered F_comb.
module my_f
    import my_f_pkg::*;
#(
    parameter logic [CfgWidth-1:0] INIT_CFG = CFG_PARITY
) (
    input  logic clk,
    input  logic rst,
    my_f_if.slave bus
);

    logic [CfgWidth-1:0] cfg_q, cfg_d;
    logic                f_q, f_d;
    logic [NumLegs-1:0]  leg_val;
    logic [2:0]          sel;

    for (genvar i = 0; i < NumLegs; i++) begin : g_leg
        my_f_leg u_leg (
            .code_i (leg_code_t'(cfg_q[2*i +: 2])),
            .d_i    (bus.D),
            .leg_o  (leg_val[i])
        );
    end

    always_comb begin
        sel   = {bus.A, bus.B, bus.C};
        f_d   = leg_val[sel];
        cfg_d = bus.cfg_we ? bus.cfg_data : cfg_q;
    end

    // f_d is built from cfg_q, so a same-edge write only takes effect on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q <= INIT_CFG;
            f_q   <= 1'b0;
        end else begin
            cfg_q <= cfg_d;
            f_q   <= f_d;
        end
    end

    assign bus.F = f_q;
`ifdef MYF_COMB_OUT_EN
    assign bus.F_comb = f_d;
`endif

endmodule

// File: tb/tb_my_f.sv
// Directed bench for my_f; also checks F_comb when MYF_COMB_OUT_EN is defined.
module tb_my_f;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    my_f_if bus_if ();

    my_f #(
        .INIT_CFG (16'hEBBE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_abcd(input logic [3:0] v);
        bus_if.A = v[3];
        bus_if.B = v[2];
        bus_if.C = v[1];
        bus_if.D = v[0];
    endtask

    initial begin
        logic [3:0] v;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        bus_if.cfg_we   = 1'b0;
        bus_if.cfg_data = 16'h0000;
        set_abcd(4'b1111);

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1 chk("reset_immediate", bus_if.F, 1'b0);
        step();
        chk("reset_hold", bus_if.F, 1'b0);
        #2 rst = 1'b0;
        step();
        chk("post_reset_1111", bus_if.F, 1'b0);
        set_abcd(4'b0001);
        step();
        chk("post_reset_0001", bus_if.F, 1'b1);

        // Default parity sweep.
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            set_abcd(v);
            step();
            chk($sformatf("parity_%b", v), bus_if.F, ^v);
        end

        // All legs constant 1.
        bus_if.cfg_data = 16'h5555;
        bus_if.cfg_we   = 1'b1;
        set_abcd(4'b0000);
        step();
        bus_if.cfg_we = 1'b0;
        set_abcd(4'b0000);
        step();
        chk("ones_0000", bus_if.F, 1'b1);
        set_abcd(4'b1010);
        step();
        chk("ones_1010", bus_if.F, 1'b1);
        set_abcd(4'b1111);
        step();
        chk("ones_1111", bus_if.F, 1'b1);

        // All legs constant 0.
        bus_if.cfg_data = 16'h0000;
        bus_if.cfg_we   = 1'b1;
        step();
        bus_if.cfg_we = 1'b0;
        set_abcd(4'b0111);
        step();
        chk("zeros_0111", bus_if.F, 1'b0);
        set_abcd(4'b1000);
        step();
        chk("zeros_1000", bus_if.F, 1'b0);

        // Restore parity, then same-edge write: F uses the old cfg on the write edge.
        bus_if.cfg_data = 16'hEBBE;
        bus_if.cfg_we   = 1'b1;
        step();
        set_abcd(4'b0000);
        bus_if.cfg_data = 16'h0001;
        bus_if.cfg_we   = 1'b1;
        step();
        chk("same_edge_old_cfg", bus_if.F, 1'b0);
        bus_if.cfg_we = 1'b0;
        step();
        chk("same_edge_new_cfg", bus_if.F, 1'b1);

        // Write 0000 while F=1, then reset mid-cycle with a write in flight.
        bus_if.cfg_data = 16'h0000;
        bus_if.cfg_we   = 1'b1;
        step();
        chk("pre_reset_f", bus_if.F, 1'b1);
        #2 rst = 1'b1;
        #1 chk("midop_reset_immediate", bus_if.F, 1'b0);
        step();
        chk("midop_reset_hold", bus_if.F, 1'b0);
        #2 rst = 1'b0;
        bus_if.cfg_we = 1'b0;
        set_abcd(4'b1000);
        step();
        chk("reset_restores_cfg_1000", bus_if.F, 1'b1);
        set_abcd(4'b1001);
        step();
        chk("reset_restores_cfg_1001", bus_if.F, 1'b0);

`ifdef MYF_COMB_OUT_EN
        set_abcd(4'b0000);
        step();
        chk("comb_0000", bus_if.F_comb, 1'b0);
        chk("reg_0000", bus_if.F, 1'b0);
        #2 set_abcd(4'b0001);
        #1 chk("comb_0001_no_clock", bus_if.F_comb, 1'b1);
        chk("reg_not_yet", bus_if.F, 1'b0);
        step();
        chk("reg_follows", bus_if.F, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/my_f.md
Name: my_f

Overview:
- Programmable 4-input Boolean function block built as an 8:1 multiplexer.
- Inputs A, B, C form the select; each of the 8 data legs is configured to constant 0, constant 1, D or ~D, so any function of A, B, C, D can be realised.
- Result F is registered on clk.
- Used as a generic LUT-style logic cell in the mux/combinational library.

Parameters:
- INIT_CFG, 16'hEBBE: configuration loaded at reset. The default realises F = A^B^C^D (4-input parity).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- A  input  1  select MSB
- B  input  1  select middle bit
- C  input  1  select LSB
- D  input  1  data variable fed to the legs
- cfg_we  input  1  configuration write enable
- cfg_data  input  16  new configuration word
- F  output  1  registered function result

Behaviour:
- Leg i (i = {A,B,C}, 0..7) is controlled by cfg[2i+1:2i].
- Leg codes: 2'b00 -> 0; 2'b01 -> 1; 2'b10 -> D; 2'b11 -> ~D.
- Combinational result: f_next = leg({A,B,C}) evaluated with the current D.
- Reset: when rst goes high, cfg <= INIT_CFG and F <= 0 immediately, with no clock required. Both hold while rst is high.
- Reset release: the first rising edge with rst low updates F.
- Each rising edge (rst low): F <= f_next. Latency is exactly 1 cycle from input change to F.
- On a rising edge with cfg_we=1: cfg <= cfg_data.
- Write and evaluate in the same edge: F uses the OLD cfg. The new cfg affects F from the following edge.
- cfg_we=0: cfg holds.
- rst asserted mid-operation: an in-flight cfg write is discarded and cfg returns to INIT_CFG.
- No X propagation: every 2-bit code is defined, so no illegal code exists.
- All outputs are driven from flops. There are no combinational paths to F.

Optional Feature:
- Macro: MYF_COMB_OUT_EN.
- When defined: adds output port F_comb (1 bit) = f_next, purely combinational and zero-latency. It uses the current cfg and is unaffected by reset except through the cfg value.
- When undefined: the port is absent and f_next is internal only. F behaviour is identical in both builds.

Decomposition:
- Package my_f_pkg contains:
  - typedef leg_code_t (2-bit)
  - constants LEG_ZERO=2'b00, LEG_ONE=2'b01, LEG_D=2'b10, LEG_ND=2'b11
  - constant CFG_PARITY=16'hEBBE
- Sub-module my_f_leg: decodes one leg_code_t plus D into a 1-bit leg value. It is instantiated 8 times; the top-level muxes the 8 leg values by {A,B,C}.

Test Plan:
- Reset defaults: assert rst with A,B,C,D=1,1,1,1 -> F=0 immediately; after release and one edge, F=0 (parity of 1111 is 0). Then set ABCD=0001 -> F=1 after one edge.
- Default parity sweep: with cfg=INIT_CFG, walk ABCD through all 16 values one per clock -> F equals A^B^C^D for each, delayed by 1 cycle.
- Reconfigure to constants: write cfg_data=16'h5555 (all legs 1) -> from the second edge after the write F=1 for every ABC D. Write 16'h0000 -> F=0.
- Same-edge write: hold ABCD=0000 with default cfg. Pulse cfg_we with 16'h0001 (leg0 = 1) on an edge -> F=0 on that edge (old cfg: leg0=D=0), F=1 on the next edge.
- Reset mid-operation: load cfg=16'h0000, then assert rst asynchronously between edges -> F=0 at once. After release, cfg=16'hEBBE, so ABCD=1000 -> F=1.
- MYF_COMB_OUT_EN build: change ABCD 0000->0001 between edges with default cfg -> F_comb goes 0->1 with no clock, and F follows on the next edge.
